game_state_ctrl: RTL

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/game_pkg.sv | 19 +
 rtl/game_state_ctrl_bcd.sv | 43 ++++
 rtl/game_state_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types for the game controller: FSM state codes, BCD digit type and
// the bit offsets of the fields packed into the quad-display word.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REGEN    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int DISP_LIVES_LSB = 28;
  localparam int DISP_STATE_LSB = 24;
  localparam int DISP_SCORE_LSB = 0;

endpackage

// File: rtl/game_state_ctrl_bcd.sv
// Four-digit BCD score counter: synchronous clear wins over increment,
// count holds at 9999; result visible the cycle after inc.
module bcd_counter4
  import game_pkg::*;
(
  input  logic              clk,
  input  logic              arst_n,
  input  logic              clr,
  input  logic              inc,
  output bcd_digit_t [3:0]  count
);

  bcd_digit_t [3:0] count_nxt;
  logic             carry;

  always_comb begin
    count_nxt = count;
    carry     = 1'b1;
    if (count != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (count[i] == 4'd9) begin
            count_nxt[i] = 4'd0;
          end else begin
            count_nxt[i] = count[i] + 4'd1;
            carry        = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Ball-vs-safe-zone game controller: per-pixel hit test on the scan stream,
// frame-rate FSM for lives/score/cooldown; decisions take effect one cycle after the last pixel.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int SCREEN_WIDTH    = 800,
  parameter int SCREEN_HEIGHT   = 600,
  parameter int BALL_RADIUS     = 20,
  parameter int START_LIVES     = 3,
  parameter int COOLDOWN_FRAMES = 60
) (
  input  logic                             clk,
  input  logic                             arst_n,
  input  logic [$clog2(SCREEN_WIDTH)-1:0]  i_screen_x,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0] i_screen_y,
  input  logic                             i_is_safe,
  input  logic [$clog2(SCREEN_WIDTH)-1:0]  i_ball_x,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0] i_ball_y,
  input  logic                             i_btn_start,
  input  logic                             i_zone_rdy,
  output logic                             o_regenerate,
  output logic [2:0]                       o_state,
  output logic                             o_hit,
  output logic [31:0]                      o_disp_data
);

  localparam int XW  = $clog2(SCREEN_WIDTH);
  localparam int YW  = $clog2(SCREEN_HEIGHT);
  localparam int SW  = 2 * ((XW > YW ? XW : YW) + 1) + 2;
  localparam int CDW = $clog2(COOLDOWN_FRAMES + 2);

  localparam logic [XW-1:0]  X_LAST     = XW'(SCREEN_WIDTH - 1);
  localparam logic [YW-1:0]  Y_LAST     = YW'(SCREEN_HEIGHT - 1);
  localparam logic [SW-1:0]  R2         = SW'(BALL_RADIUS * BALL_RADIUS);
  localparam logic [3:0]     LIVES_INIT = 4'(START_LIVES);
  localparam logic [CDW-1:0] CD_INIT    = CDW'(COOLDOWN_FRAMES);

  logic [XW-1:0]    x_d, ball_x_q, bx;
  logic [YW-1:0]    y_d, ball_y_q, by;
  logic             btn_q, start_ev;
  logic             at_origin, frame_end;
  logic [XW:0]      dx;
  logic [YW:0]      dy;
  logic [SW-1:0]    dx_e, dy_e, dist2;
  logic             pix_hit, frame_hit, hit_now;

  state_t           state, state_nxt;
  logic [3:0]       lives, lives_nxt;
  logic [CDW-1:0]   cd_cnt, cd_nxt;
  logic             regen_nxt, hit_nxt, score_inc, score_clr;
  bcd_digit_t [3:0] score;
  logic [31:0]      disp_nxt;

  assign at_origin = (x_d == '0) && (y_d == '0);
  assign frame_end = (x_d == X_LAST) && (y_d == Y_LAST);
  assign start_ev  = i_btn_start && !btn_q;

  // The origin pixel itself is tested against the ball position being latched now.
  assign bx    = at_origin ? i_ball_x : ball_x_q;
  assign by    = at_origin ? i_ball_y : ball_y_q;
  assign dx    = {1'b0, x_d} - {1'b0, bx};
  assign dy    = {1'b0, y_d} - {1'b0, by};
  assign dx_e  = {{(SW-XW-1){dx[XW]}}, dx};
  assign dy_e  = {{(SW-YW-1){dy[YW]}}, dy};
  assign dist2 = dx_e * dx_e + dy_e * dy_e;

  assign pix_hit = (dist2 <= R2) && !i_is_safe;
  assign hit_now = (at_origin ? 1'b0 : frame_hit) | pix_hit;

  always_comb begin
    state_nxt = state;
    lives_nxt = lives;
    cd_nxt    = cd_cnt;
    regen_nxt = 1'b0;
    hit_nxt   = 1'b0;
    score_inc = 1'b0;
    score_clr = 1'b0;
    case (state)
      ST_IDLE, ST_GAMEOVER: begin
        if (start_ev) begin
          regen_nxt = 1'b1;
          lives_nxt = LIVES_INIT;
          score_clr = 1'b1;
          state_nxt = ST_REGEN;
        end
      end
      ST_REGEN: begin
        // o_regenerate is high only in the first REGEN cycle; a ready seen then is stale.
        if (frame_end && i_zone_rdy && !o_regenerate) state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (frame_end) begin
          if (hit_now) begin
            hit_nxt   = 1'b1;
            lives_nxt = lives - 4'd1;
            if (lives <= 4'd1) begin
              state_nxt = ST_GAMEOVER;
            end else begin
              state_nxt = ST_COOLDOWN;
              cd_nxt    = CD_INIT;
            end
          end else begin
            score_inc = 1'b1;
          end
        end
      end
      ST_COOLDOWN: begin
        if (frame_end) begin
          if (cd_cnt <= CDW'(1)) begin
            cd_nxt    = '0;
            state_nxt = ST_PLAY;
          end else begin
            cd_nxt = cd_cnt - CDW'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    disp_nxt = '0;
    disp_nxt[DISP_LIVES_LSB +: 4]  = lives;
    disp_nxt[DISP_STATE_LSB +: 3]  = state;
    disp_nxt[DISP_SCORE_LSB +: 16] = score;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      x_d          <= '0;
      y_d          <= '0;
      btn_q        <= 1'b0;
      ball_x_q     <= '0;
      ball_y_q     <= '0;
      frame_hit    <= 1'b0;
      state        <= ST_IDLE;
      lives        <= LIVES_INIT;
      cd_cnt       <= '0;
      o_regenerate <= 1'b0;
      o_hit        <= 1'b0;
      o_disp_data  <= {LIVES_INIT, 28'h0};
    end else begin
      x_d          <= i_screen_x;
      y_d          <= i_screen_y;
      btn_q        <= i_btn_start;
      if (at_origin) begin
        ball_x_q <= i_ball_x;
        ball_y_q <= i_ball_y;
      end
      frame_hit    <= hit_now;
      state        <= state_nxt;
      lives        <= lives_nxt;
      cd_cnt       <= cd_nxt;
      o_regenerate <= regen_nxt;
      o_hit        <= hit_nxt;
      o_disp_data  <= disp_nxt;
    end
  end

  assign o_state = state;

  bcd_counter4 u_score (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (score_clr),
    .inc    (score_inc),
    .count  (score)
  );

endmodule
